// File: rtl/key_hash_if.sv
// key_hash_if: groups the FWFT FIFO read port and the downstream valid/ready
// output bus of key_hash_unit. The slave modport is the hashing block's view;
// the master modport is the view of whatever surrounds it (FIFO + lookup stage).
interface key_hash_if #(
    parameter int HASH_W = 16
);
    logic [127:0]        fifo_dout;
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [127:0]        out_key;
    logic [HASH_W-1:0]   out_hash;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         key_cnt;
    logic                busy;

    modport slave (
        input  fifo_dout, fifo_empty, out_ready,
        output fifo_rd_en, out_key, out_hash, out_valid, key_cnt, busy
    );

    modport master (
        output fifo_dout, fifo_empty, out_ready,
        input  fifo_rd_en, out_key, out_hash, out_valid, key_cnt, busy
    );
endinterface

// File: rtl/key_hash_unit.sv
// key_hash_unit: pops 128-bit keys from an FWFT FIFO, mixes the four 32-bit
// words into a 32-bit state with a rotate-left-5/XOR round (word 0 first),
// folds the state to a HASH_W-bit bucket index and presents key + index on a
// valid/ready bus. One key every 6 cycles with the sink always ready.
// Optional build macro KEYHASH_STATS_EN enables the accepted-key counter;
// without it key_cnt is tied to zero.
module key_hash_unit #(
    parameter int          KEY_W  = 128,
    parameter int          HASH_W = 16,
    parameter logic [31:0] SEED   = 32'h811C9DC5
) (
    input  logic        rd_clk,
    input  logic        rst_n,
    key_hash_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        h_q, h_d;
    logic [1:0]         rnd_q, rnd_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [31:0]        word_s;
    logic               pop_s;

    // Fold the 32-bit mix state down to the bucket index width.
    function automatic logic [HASH_W-1:0] fold(input logic [31:0] h);
        return h[HASH_W-1:0] ^ h[31 -: HASH_W];
    endfunction

    // Key word consumed by the current round; word 0 sits in bits 31:0.
    assign word_s = key_q[{rnd_q, 5'd0} +: 32];

    // Pop only from IDLE on a non-empty FIFO. Gated with rst_n so no key is
    // drained from the FIFO while the block is held in reset.
    assign pop_s = rst_n && (state_q == IDLE) && !bus.fifo_empty;

    // Next-state logic: latch on pop, four mix rounds, then hold in OUT until accepted.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    key_d   = bus.fifo_dout;
                    h_d     = SEED;
                    rnd_d   = 2'd0;
                    state_d = HASH;
                end else begin
                    state_d = IDLE;
                end
            end
            HASH: begin
                h_d   = {h_q[26:0], h_q[31:27]} ^ word_s;
                rnd_d = rnd_q + 2'd1;
                if (rnd_q == 2'd3) begin
                    state_d = OUT;
                end else begin
                    state_d = HASH;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, mix state, round index and captured key registers.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= 32'h0000_0000;
            rnd_q   <= 2'd0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
        end
    end

`ifdef KEYHASH_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic        accept_s;

    assign accept_s = (state_q == OUT) && bus.out_ready;

    // Accepted-key count, wrapping naturally at 16 bits.
    always_comb begin
        if (accept_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.key_cnt = cnt_q;
`else
    assign bus.key_cnt = 16'h0000;
`endif

    assign bus.fifo_rd_en = pop_s;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_key    = key_q[127:0];
    assign bus.out_hash   = fold(h_q);

endmodule

// File: tb/tb_key_hash_unit.sv
// tb_key_hash_unit: randomized self-checking bench for key_hash_unit. Keys are
// pushed into a queue-modelled FWFT FIFO; popped keys enter an expected queue
// and every accepted output is compared against a closed-form hash model.
module tb_key_hash_unit;
    localparam int          HASH_W = 16;
    localparam logic [31:0] SEED   = 32'h811C9DC5;

    logic rd_clk = 1'b0;
    logic rst_n;

    always #5 rd_clk = ~rd_clk;

    key_hash_if #(.HASH_W(HASH_W)) bus ();

    key_hash_unit #(.HASH_W(HASH_W), .SEED(SEED)) dut (
        .rd_clk (rd_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] fifo_q [$];
    logic [127:0] exp_q  [$];
    int   cyc          = 0;
    int   last_pop_cyc = -1;
    int   n_pops       = 0;
    int   n_accepts    = 0;
    int   cnt_model    = 0;
    bit   gap_chk      = 1'b0;
    logic prev_valid   = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Unrolled closed form: each word is rotated by 5 for every round after it.
    function automatic logic [HASH_W-1:0] ref_hash(input logic [127:0] k);
        logic [31:0] h;
        h = rotl(SEED, 20) ^ rotl(k[31:0], 15) ^ rotl(k[63:32], 10)
          ^ rotl(k[95:64], 5) ^ k[127:96];
        return h[HASH_W-1:0] ^ HASH_W'(h >> (32 - HASH_W));
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef KEYHASH_STATS_EN
        return 16'(cnt_model);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic drive_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() == 0) ? 128'h0 : fifo_q[0];
    endtask

    task automatic tick();
        logic pop_s, acc_s;
        @(negedge rd_clk);
        pop_s = bus.fifo_rd_en;
        acc_s = bus.out_valid && bus.out_ready;
        if (bus.fifo_empty) check("rd_en_empty", {127'h0, bus.fifo_rd_en}, 128'h0);
        if (pop_s) check("pop_only_idle", {126'h0, bus.busy, bus.out_valid}, 128'h0);
        if (acc_s) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 128'h1, 128'h0);
            end else begin
                check("out_key", bus.out_key, exp_q[0]);
                check("out_hash", 128'(bus.out_hash), 128'(ref_hash(exp_q[0])));
                void'(exp_q.pop_front());
            end
            cnt_model++;
            n_accepts++;
        end
        @(posedge rd_clk);
        #1;
        cyc++;
        if (pop_s) begin
            if (fifo_q.size() > 0) exp_q.push_back(fifo_q.pop_front());
            if (gap_chk && last_pop_cyc >= 0) check("pop_gap", 128'(cyc - last_pop_cyc), 128'd6);
            last_pop_cyc = cyc;
            n_pops++;
        end
        if (bus.out_valid && !prev_valid) check("valid_latency", 128'(cyc - last_pop_cyc), 128'd4);
        prev_valid = bus.out_valid;
        if (acc_s) check("key_cnt", 128'(bus.key_cnt), 128'(exp_cnt()));
        drive_fifo();
    endtask

    task automatic drain(input int limit);
        bit done;
        bus.out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !bus.out_valid && !bus.busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("drain_timeout", 128'h1, 128'h0);
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !bus.out_valid; i++) tick();
        if (!bus.out_valid) check("wait_valid_timeout", 128'h1, 128'h0);
    endtask

    task automatic run_const(input logic [127:0] key, input logic [15:0] hash);
        int pops0;
        pops0 = n_pops;
        bus.out_ready = 1'b1;
        fifo_q.push_back(key);
        drive_fifo();
        wait_valid(12);
        check("hash_const", 128'(bus.out_hash), 128'(hash));
        drain(20);
        check("single_pop", 128'(n_pops - pops0), 128'd1);
        check("cnt_after", 128'(bus.key_cnt), 128'(exp_cnt()));
    endtask

    initial begin
        logic [127:0] snap_key;
        logic [15:0]  snap_hash;
        int           acc0;

        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive_fifo();
        #12;
        check("rst_outputs", {bus.fifo_rd_en, bus.out_valid, bus.busy, bus.key_cnt, bus.out_hash},
              128'h0);
        check("rst_key", bus.out_key, 128'h0);
        rst_n = 1'b1;

        // Empty FIFO: nothing moves.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", {111'h0, bus.fifo_rd_en, bus.out_valid, bus.busy, bus.key_cnt},
                  128'h0);
        end

        // Known-answer keys.
        run_const(128'h0, 16'hCD91);
        run_const(128'h1, 16'h4D91);
        run_const({128{1'b1}}, 16'hCD91);

        // Ten queued keys, sink always ready: pops 6 cycles apart, in order.
        acc0 = n_accepts;
        for (int i = 0; i < 10; i++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        drive_fifo();
        gap_chk      = 1'b1;
        last_pop_cyc = -1;
        drain(120);
        gap_chk = 1'b0;
        check("ten_accepts", 128'(n_accepts - acc0), 128'd10);
        check("ten_cnt", 128'(bus.key_cnt), 128'(exp_cnt()));

        // Backpressure: held output, no pops while stalled, then one accept.
        bus.out_ready = 1'b0;
        fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        drive_fifo();
        wait_valid(12);
        snap_key  = bus.out_key;
        snap_hash = bus.out_hash;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("bp_stable", {bus.fifo_rd_en, bus.out_valid, bus.out_hash, bus.out_key[109:0]},
                  {1'b0, 1'b1, snap_hash, snap_key[109:0]});
        end
        acc0 = n_accepts;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_one_accept", 128'(n_accepts - acc0), 128'd1);
        check("bp_valid_drop", {127'h0, bus.out_valid}, 128'h0);
        drain(40);

        // Reset while in HASH round 2: the in-flight key is lost.
        bus.out_ready = 1'b1;
        fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        drive_fifo();
        for (int i = 0; i < 5 && !bus.busy; i++) tick();
        check("rst_test_popped", {127'h0, bus.busy}, 128'h1);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.fifo_rd_en, bus.out_valid, bus.busy, bus.key_cnt, bus.out_hash},
              128'h0);
        check("midrst_key", bus.out_key, 128'h0);
        exp_q.delete();
        cnt_model    = 0;
        prev_valid   = 1'b0;
        last_pop_cyc = -1;
        #1;
        rst_n = 1'b1;
        check("post_rst_cnt", 128'(bus.key_cnt), 128'h0);
        drain(40);
        check("post_rst_cnt_end", 128'(bus.key_cnt), 128'(exp_cnt()));

        // Random traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
            bus.out_ready = 1'($urandom_range(0, 1));
            drive_fifo();
            tick();
        end
        drain(400);
        check("final_cnt", 128'(bus.key_cnt), 128'(exp_cnt()));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/key_hash_unit.md
# key_hash_unit

- Consumes 128-bit keys from the KeyHash FIFO's first-word-fall-through read port.
- Computes a HASH_W-bit bucket index per key with a 4-round, 32-bit rotate/XOR mix.
- Presents key and index downstream on a valid/ready interface.
- Sits directly downstream of the KeyHash FIFO, in the read-clock domain, and feeds the bucket lookup stage.

## Interface
- KEY_W, 128: key width; fixed at 128 (four 32-bit words).
- HASH_W, 16: bucket index width; legal range 8..16.
- SEED, 32'h811C9DC5: initial hash state.
- rd_clk  in  1  single clock, the FIFO read clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_dout  in  128  FWFT head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe; combinational.
- out_key  out  128  key being presented downstream.
- out_hash  out  HASH_W  bucket index for out_key.
- out_valid  out  1  out_key/out_hash are valid.
- out_ready  in  1  downstream accepts the current output.
- key_cnt  out  16  count of keys accepted downstream (stats).
- busy  out  1  high whenever state != IDLE.

## Operation
- **FSM states:** IDLE, HASH, OUT. State encoding is free.
- **Pop:**
  - fifo_rd_en = (state==IDLE) && !fifo_empty.
  - Pop and latch happen on the same edge: key_r<=fifo_dout, h<=SEED, rnd<=0, state->HASH.
- **HASH (4 cycles):**
  - Each cycle: h <= {h[26:0],h[31:27]} ^ key_r[32*rnd+31 -: 32]; rnd <= rnd+1.
  - Word 0 (bits 31:0) is processed first.
  - At rnd==3, the edge applies the last round and moves to OUT.
- **Fold:** out_hash = h[HASH_W-1:0] ^ h[31 -: HASH_W]. The fold is combinational from the registered h.
- **OUT:**
  - out_valid=1; out_key=key_r.
  - out_key, out_hash and out_valid are held stable until out_ready=1 at a rising edge.
  - On that edge: state->IDLE and key_cnt increments.
- **No pop outside IDLE:** fifo_rd_en is never asserted in HASH or OUT, even if the FIFO is non-empty.
- **Empty FIFO:** the FSM stays in IDLE with fifo_rd_en=0.
- **key_cnt:** wraps 16'hFFFF -> 16'h0000.
- **Reset values:**
  - Outputs: fifo_rd_en=0, out_valid=0, busy=0, out_key=0, out_hash=fold(0)=0, key_cnt=0.
  - Internal: state=IDLE, h=0, rnd=0.
- **Reset mid-operation:** asserting rst_n drops any key in flight (already popped) with no re-push. Resumes from IDLE after release.

## Timing
- Pop at edge E0.
- out_valid is registered high after edge E4, i.e. 4 cycles after the pop edge.
- **Throughput:**
  - With out_ready held high, one key per 6 cycles: pop, 4 hash cycles, 1 OUT cycle.
  - The next pop is the cycle after leaving OUT.
- **Backpressure:** out_ready low holds OUT indefinitely. out_ready is ignored outside OUT.
- **FIFO coupling:** fifo_empty is sampled only in IDLE; fifo_dout is sampled only on the pop edge.
- **Reset release:** rst_n deasserts asynchronously to the block. The first possible pop is the first rd_clk edge after release.

## Configuration
- Macro: KEYHASH_STATS_EN.
- Defined: key_cnt counts as specified.
- Undefined: the counter logic is removed and key_cnt is tied to 16'h0000. The port still exists; all other behaviour is identical.

## Test plan
- Reset, FIFO empty, 20 cycles: fifo_rd_en=0, out_valid=0, busy=0, key_cnt=0 throughout.
- fifo_dout=128'h0, out_ready=1:
  - One fifo_rd_en pulse.
  - out_valid high exactly 4 cycles later, with out_hash=16'hCD91.
  - key_cnt=1.
- fifo_dout=128'h1: out_hash=16'h4D91. fifo_dout=all-ones: out_hash=16'hCD91.
- 10 keys queued, out_ready=1:
  - 10 pops spaced 6 cycles apart; key_cnt=10.
  - Each out_key matches pop order.
- Backpressure:
  - out_ready=0 for 15 cycles in OUT: outputs stable, fifo_rd_en=0 throughout.
  - Then out_ready=1 for one edge: a single accept.
- Reset during HASH round 2: all outputs return to reset values immediately. After release, the next queued key is popped normally and key_cnt is unchanged from 0.
- Without KEYHASH_STATS_EN: repeat the 10-key test; key_cnt stays 0 and hashes are identical.
